// File: rtl/tt_um_hoene_frame_controller_pkg.sv
// Shared state encodings and parameter defaults for the frame controller.
package tt_um_hoene_frame_controller_pkg;

  localparam int FRAME_BITS_DEFAULT = 32;
  localparam int TIMEOUT_W_DEFAULT  = 20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECV = 3'd1,
    FWD  = 3'd2,
    ERR  = 3'd3
  } state_t;

endpackage

// File: rtl/tt_um_hoene_frame_watchdog.sv
// LED blanking watchdog: counts down from all-ones after each good frame, blank once it hits zero.
// Reload and blank both take effect on the clock edge after reload is sampled; no backpressure.
module tt_um_hoene_frame_watchdog
  import tt_um_hoene_frame_controller_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic blank
);

  logic [TIMEOUT_W-1:0] count;
  logic [TIMEOUT_W-1:0] nxt_count;

  always_comb begin
    nxt_count = count;
    if (reload) begin
      nxt_count = '1;
    end else if (count != '0) begin
      nxt_count = count - 1'b1;
    end
  end

  // blank is derived from the next count so it drops in the same cycle as store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      blank <= 1'b1;
    end else begin
      count <= nxt_count;
      blank <= (nxt_count == '0);
    end
  end

endmodule

// File: rtl/tt_um_hoene_frame_controller.sv
// Frame sequencer: steers the first FRAME_BITS bits to the shift register, the rest downstream, then stores good frames.
// One clk from in_valid to shift_en/fwd_valid and from sync drop to store; no backpressure, every strobe is consumed.
module tt_um_hoene_frame_controller
  import tt_um_hoene_frame_controller_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int TIMEOUT_W  = TIMEOUT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_data,
  input  logic       in_sync,
  input  logic       in_error,
  output logic       shift_en,
  output logic       shift_data,
  output logic       fwd_valid,
  output logic       fwd_data,
  output logic       store,
  output logic       blank,
  output logic       frame_error,
  output logic [7:0] frame_count,
  output logic [2:0] state
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] nxt_bit_cnt;
  logic             parity;
  logic             nxt_parity;
  logic             nxt_shift_en;
  logic             nxt_fwd_valid;
  logic             nxt_store;
  logic             nxt_frame_error;

  always_comb begin
    nxt_state       = cur_state;
    nxt_bit_cnt     = bit_cnt;
    nxt_parity      = parity;
    nxt_shift_en    = 1'b0;
    nxt_fwd_valid   = 1'b0;
    nxt_store       = 1'b0;
    nxt_frame_error = 1'b0;

    case (cur_state)
      IDLE: begin
        if (in_sync && !in_error) begin
          nxt_state   = RECV;
          nxt_bit_cnt = '0;
          nxt_parity  = 1'b0;
          if (in_valid) begin
            nxt_shift_en = 1'b1;
            nxt_parity   = in_data;
            nxt_bit_cnt  = CNT_W'(1);
          end
        end
      end

      RECV: begin
        if (in_error) begin
          nxt_frame_error = 1'b1;
          nxt_state       = ERR;
        end else begin
          if (in_valid) begin
            nxt_shift_en = 1'b1;
            nxt_parity   = parity ^ in_data;
            nxt_bit_cnt  = bit_cnt + CNT_W'(1);
          end
          // A parity bit coinciding with the sync drop still completes the frame
          if (nxt_bit_cnt == FULL_CNT) begin
            if (!in_sync) begin
              if (!nxt_parity) begin
                nxt_store = 1'b1;
                nxt_state = IDLE;
              end else begin
                nxt_frame_error = 1'b1;
                nxt_state       = ERR;
              end
            end else begin
              nxt_state = FWD;
            end
          end else if (!in_sync) begin
            nxt_frame_error = 1'b1;
            nxt_state       = ERR;
          end
        end
      end

      FWD: begin
        if (in_error) begin
          nxt_frame_error = 1'b1;
          nxt_state       = ERR;
        end else begin
          nxt_fwd_valid = in_valid;
          if (!in_sync) begin
            if (!parity) begin
              nxt_store = 1'b1;
              nxt_state = IDLE;
            end else begin
              nxt_frame_error = 1'b1;
              nxt_state       = ERR;
            end
          end
        end
      end

      ERR: begin
        if (!in_sync) begin
          nxt_state = IDLE;
        end
      end

      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state   <= IDLE;
      bit_cnt     <= '0;
      parity      <= 1'b0;
      shift_en    <= 1'b0;
      shift_data  <= 1'b0;
      fwd_valid   <= 1'b0;
      fwd_data    <= 1'b0;
      store       <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      cur_state   <= nxt_state;
      bit_cnt     <= nxt_bit_cnt;
      parity      <= nxt_parity;
      shift_en    <= nxt_shift_en;
      fwd_valid   <= nxt_fwd_valid;
      store       <= nxt_store;
      frame_error <= nxt_frame_error;
      if (nxt_shift_en) begin
        shift_data <= in_data;
      end
      if (nxt_fwd_valid) begin
        fwd_data <= in_data;
      end
      if (nxt_store) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign state = cur_state;

  tt_um_hoene_frame_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .reload(nxt_store),
    .blank (blank)
  );

endmodule
